// File: rtl/conv_kxk_stream_if.sv
// Pixel-in / result-out handshake bundle for conv_kxk_stream.
// Widths derive from DATA_W and K so both ends agree on ACC_W.
interface conv_kxk_stream_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3
);
  localparam int ACC_W = 2*DATA_W + $clog2(K*K);

  logic                       in_valid;
  logic                       in_ready;
  logic signed [DATA_W-1:0]   pixel_in;
  logic [K*K*DATA_W-1:0]      weights;
  logic                       out_valid;
  logic                       out_ready;
  logic signed [ACC_W-1:0]    out_data;
  logic                       out_last;

  modport master (
    output in_valid, pixel_in, weights, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, pixel_in, weights, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_kxk_stream.sv
// Streaming KxK signed convolution: window register, product stage, sum stage.
// Optional macro CONV_RELU_EN clamps negative sums to zero in the sum stage.
module conv_kxk_stream #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4
)(
  input  logic              clk,
  input  logic              rst,
  conv_kxk_stream_if.slave  bus
);
  localparam int ACC_W  = 2*DATA_W + $clog2(K*K);
  localparam int PW     = 2*DATA_W;
  localparam int NT     = K*K;
  localparam int L      = (K-1)*IMG_W + K;
  localparam int STAGES = 2;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W-1);
  localparam logic [CW-1:0] COL_MIN = CW'(K-1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H-1);
  localparam logic [RW-1:0] ROW_MIN = RW'(K-1);

  logic                     w_stall, w_acc, w_win, w_lastpos;
  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_sr [L];
  logic [STAGES:0]          r_vld_pipe;
  logic [STAGES:0]          r_last_pipe;
  logic signed [PW-1:0]     r_prod [NT];
  logic signed [ACC_W-1:0]  w_sum, w_res, r_out;

  assign w_stall      = r_vld_pipe[STAGES] && !bus.out_ready;
  assign bus.in_ready = !rst && !w_stall;
  assign w_acc        = bus.in_valid && bus.in_ready;
  assign w_win        = (r_row >= ROW_MIN) && (r_col >= COL_MIN);
  assign w_lastpos    = (r_row == ROW_MAX) && (r_col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // One flat shift chain holds K-1 full rows plus the current row's K taps.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_sr[0] <= bus.pixel_in;
      for (int i = 1; i < L; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  // The whole pipe advances together; a stall freezes every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (!w_stall) begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:0], w_acc && w_win};
      r_last_pipe <= {r_last_pipe[STAGES-1:0], w_acc && w_win && w_lastpos};
    end
  end

  // Tap (r,c) sits (K-1-r) rows and (K-1-c) columns behind the newest pixel.
  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      localparam int T   = gr*K + gc;
      localparam int IDX = (K-1-gr)*IMG_W + (K-1-gc);
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_prod[T] <= '0;
        else if (!w_stall && r_vld_pipe[0])
          r_prod[T] <= PW'(r_sr[IDX]) * PW'($signed(bus.weights[T*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NT; i++) w_sum = w_sum + ACC_W'(r_prod[i]);
  end

`ifdef CONV_RELU_EN
  assign w_res = w_sum[ACC_W-1] ? '0 : w_sum;
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_out <= '0;
    else if (!w_stall && r_vld_pipe[1])
      r_out <= w_res;
  end

  assign bus.out_valid = r_vld_pipe[STAGES];
  assign bus.out_data  = r_out;
  assign bus.out_last  = r_last_pipe[STAGES];
endmodule

// File: tb/tb_conv_kxk_stream.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop and compare.
// DUT A is K=3 4x4; DUT B is K=2 5x3.
module tb_conv_kxk_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_kxk_stream_if #(.DATA_W(8), .K(3)) ia();
  conv_kxk_stream_if #(.DATA_W(8), .K(2)) ib();

  conv_kxk_stream #(.DATA_W(8), .K(3), .IMG_W(4), .IMG_H(4)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  conv_kxk_stream #(.DATA_W(8), .K(2), .IMG_W(5), .IMG_H(3)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct {int val; bit last; int cyc;} exp_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int n_cmp = 0, n_bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL A_extra: got result %0d, expected none", ia.out_data);
      end else begin
        ea = qa.pop_front();
        chk("A_data", ia.out_data, ea.val);
        chk("A_last", int'(ia.out_last), int'(ea.last));
        if (ea.cyc >= 0) chk("A_latency", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL B_extra: got result %0d, expected none", ib.out_data);
      end else begin
        eb = qb.pop_front();
        chk("B_data", ib.out_data, eb.val);
        chk("B_last", int'(ib.out_last), int'(eb.last));
      end
    end
  end

  // Present one pixel after `gap` idle cycles and hold it until accepted.
  task automatic send(input bit b, input int p, input int gap);
    bit acc, ok;
    repeat (gap) begin @(posedge clk); #1; end
    if (b) begin ib.in_valid = 1'b1; ib.pixel_in = 8'(p); end
    else   begin ia.in_valid = 1'b1; ia.pixel_in = 8'(p); end
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = b ? ib.in_ready : ia.in_ready;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got no accept in 100 cycles, expected accept of pixel %0d", p);
    end
  endtask

  task automatic run_a(input int pix[16], input int ex[4], input bit lat, input int maxgap);
    int n = 0;
    for (int k = 0; k < 16; k++) begin
      send(1'b0, pix[k], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (k/4 >= 2 && k%4 >= 2) begin
        qa.push_back('{val: ex[n], last: (k == 15), cyc: lat ? cyc + 2 : -1});
        n++;
      end
    end
  endtask

  task automatic stall_chk();
    bit seen = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (ia.out_valid) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL A_stall_wait: got no out_valid in 100 cycles, expected a result");
    end else begin
      for (int i = 0; i < 5; i++) begin
        chk("A_stall_data", ia.out_data, 54);
        chk("A_stall_ready", int'(ia.in_ready), 0);
        @(negedge clk);
      end
    end
    @(posedge clk); #1;
    ia.out_ready = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && (qa.size() + qb.size()) > 0; t++) @(negedge clk);
    while (qa.size() > 0) begin
      ea = qa.pop_front(); n_cmp++; n_bad++;
      $display("FAIL A_missing: got nothing, expected %0d", ea.val);
    end
    while (qb.size() > 0) begin
      eb = qb.pop_front(); n_cmp++; n_bad++;
      $display("FAIL B_missing: got nothing, expected %0d", eb.val);
    end
    @(posedge clk); #1;
  endtask

  int p1[16], p2[16];
  int e1[4]   = '{54, 63, 90, 99};
  int erev[4] = '{99, 90, 63, 54};
`ifdef CONV_RELU_EN
  int eneg[4] = '{0, 0, 0, 0};
`else
  int eneg[4] = '{-54, -63, -90, -99};
`endif
  int e6[8]   = '{51, 61, 71, 81, 101, 111, 121, 131};

  initial begin
    for (int k = 0; k < 16; k++) begin p1[k] = k + 1; p2[k] = 16 - k; end
    ia.in_valid = 1'b0; ia.pixel_in = '0; ia.out_ready = 1'b1; ia.weights = {9{8'sd1}};
    ib.in_valid = 1'b0; ib.pixel_in = '0; ib.out_ready = 1'b1;
    ib.weights = {8'sd4, 8'sd3, 8'sd2, 8'sd1};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(ia.in_ready), 0);
    chk("rst_out_valid", int'(ia.out_valid), 0);
    chk("rst_out_data", ia.out_data, 0);
    chk("rst_out_last", int'(ia.out_last), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(ia.in_ready), 1);
    @(posedge clk); #1;

    // 1: ramp, unit weights, latency check
    run_a(p1, e1, 1'b1, 0);
    drain();

    // 2: negative weights
    ia.weights = {9{8'hFF}};
    run_a(p1, eneg, 1'b0, 0);
    drain();

    // 3: backpressure on the first result
    ia.weights = {9{8'sd1}};
    ia.out_ready = 1'b0;
    fork
      run_a(p1, e1, 1'b0, 0);
      stall_chk();
    join
    drain();

    // 4: back-to-back frames with random gaps
    run_a(p1, e1, 1'b0, 2);
    run_a(p2, erev, 1'b0, 2);
    drain();

    // 5: reset mid-frame
    for (int k = 0; k < 7; k++) send(1'b0, k + 1, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_in_ready", int'(ia.in_ready), 0);
      chk("midrst_out_valid", int'(ia.out_valid), 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    run_a(p1, e1, 1'b0, 0);
    drain();

    // 6: K=2 on a 5x3 frame
    begin
      int n = 0;
      for (int k = 0; k < 15; k++) begin
        send(1'b1, k + 1, 0);
        if (k/5 >= 1 && k%5 >= 1) begin
          qb.push_back('{val: e6[n], last: (k == 14), cyc: -1});
          n++;
        end
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
